// File: rtl/irq_ctl_pkg.sv
// Shared constants and helpers for the irq_ctl interrupt controller.
package irq_ctl_pkg;
  localparam int NUM_IRQ = 8;
  localparam int COUNT_W = 16;

  localparam logic [4:0] OFF_PENDING  = 5'h00;
  localparam logic [4:0] OFF_MASK     = 5'h04;
  localparam logic [4:0] OFF_OVERFLOW = 5'h08;
  localparam logic [4:0] OFF_COUNT    = 5'h0C;
  localparam logic [4:0] OFF_SWSET    = 5'h10;

  // Word index within the 32-byte window, taken from address bits [4:2].
  typedef enum logic [2:0] {
    REG_PENDING  = OFF_PENDING[4:2],
    REG_MASK     = OFF_MASK[4:2],
    REG_OVERFLOW = OFF_OVERFLOW[4:2],
    REG_COUNT    = OFF_COUNT[4:2],
    REG_SWSET    = OFF_SWSET[4:2]
  } reg_sel_e;

  function automatic logic [3:0] popcount(input logic [NUM_IRQ-1:0] v);
    logic [3:0] pc;
    pc = '0;
    for (int i = 0; i < NUM_IRQ; i++) pc = pc + 4'(v[i]);
    return pc;
  endfunction
endpackage

// File: rtl/irq_ctl_if.sv
// Data-bus view of the controller: core drives address/data/strobe, controller returns load data.
interface irq_ctl_if;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;

  modport master (output dataadr, output writedata, output memwrite, input  readdata);
  modport slave  (input  dataadr, input  writedata, input  memwrite, output readdata);
endinterface

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for asynchronous request lines plus a history flop for rise detection.
module irq_sync_edge #(
  parameter int W = 8
) (
  input  logic         ph1,
  input  logic         reset_b,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);
  logic [W-1:0] sync1_q, sync1_d;
  logic [W-1:0] sync2_q, sync2_d;
  logic [W-1:0] prev_q,  prev_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // A held level yields one event; the line must drop to re-arm.
  assign rise = sync2_q & ~prev_q;
endmodule

// File: rtl/irq_ctl.sv
// Memory-mapped interrupt controller: latches device/software events as pending,
// masks them onto the core's level interrupt lines, tracks overflow and an event count.
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter logic [31:0]        BASE       = 32'hFFFF_FF00,
  parameter logic [NUM_IRQ-1:0] MASK_RESET = 8'hFF
) (
  input  logic               ph1,
  input  logic               reset_b,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_ctl_if.slave           bus,
  output logic [NUM_IRQ-1:0] interrupts
);
  logic [NUM_IRQ-1:0] pending_q,  pending_d;
  logic [NUM_IRQ-1:0] mask_q,     mask_d;
  logic [NUM_IRQ-1:0] overflow_q, overflow_d;
  logic [COUNT_W-1:0] count_q,    count_d;

  logic [NUM_IRQ-1:0] rise, sw_set, pend_clr, ovf_clr, ev, accepted, ovf_new;
  logic [NUM_IRQ-1:0] wdata;
  logic               hit, wr, cnt_clr;
  reg_sel_e           sel;
  logic               unused_bits;

  irq_sync_edge #(.W(NUM_IRQ)) u_sync (
    .ph1     (ph1),
    .reset_b (reset_b),
    .d       (irq_in),
    .rise    (rise)
  );

  assign hit         = (bus.dataadr[31:5] == BASE[31:5]);
  assign wr          = bus.memwrite & hit;
  assign sel         = reg_sel_e'(bus.dataadr[4:2]);
  assign wdata       = bus.writedata[NUM_IRQ-1:0];
  assign unused_bits = ^{bus.writedata[31:NUM_IRQ], bus.dataadr[1:0]};

  always_comb begin
    sw_set   = '0;
    pend_clr = '0;
    ovf_clr  = '0;
    cnt_clr  = 1'b0;
    mask_d   = mask_q;
    if (wr) begin
      case (sel)
        REG_PENDING:  pend_clr = wdata;
        REG_MASK:     mask_d   = wdata;
        REG_OVERFLOW: ovf_clr  = wdata;
        REG_COUNT:    cnt_clr  = 1'b1;
        REG_SWSET:    sw_set   = wdata;
        default:      ;
      endcase
    end

    ev = rise | sw_set;
    // A same-cycle W1C frees the slot, so a coincident event is accepted, not overflowed.
    accepted = ev & (~pending_q | pend_clr);
    ovf_new  = ev & pending_q & ~pend_clr;

    pending_d  = (pending_q & ~pend_clr) | accepted;
    overflow_d = (overflow_q & ~ovf_clr) | ovf_new;
    count_d    = (cnt_clr ? '0 : count_q) + COUNT_W'(popcount(accepted));
  end

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      pending_q  <= '0;
      mask_q     <= MASK_RESET;
      overflow_q <= '0;
      count_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    if (hit) begin
      case (sel)
        REG_PENDING:  bus.readdata = {{(32-NUM_IRQ){1'b0}}, pending_q};
        REG_MASK:     bus.readdata = {{(32-NUM_IRQ){1'b0}}, mask_q};
        REG_OVERFLOW: bus.readdata = {{(32-NUM_IRQ){1'b0}}, overflow_q};
        REG_COUNT:    bus.readdata = {{(32-COUNT_W){1'b0}}, count_q};
        default:      bus.readdata = '0;
      endcase
    end
  end

  assign interrupts = pending_q & mask_q;
endmodule

// File: tb/tb_irq_ctl.sv
// Randomized + directed bench for irq_ctl against a bit-by-bit behavioural model.
module tb_irq_ctl;
  import irq_ctl_pkg::*;

  localparam logic [31:0] B = 32'hFFFF_FF00;
  localparam logic [31:0] A_PEND = B + 32'(OFF_PENDING);
  localparam logic [31:0] A_MASK = B + 32'(OFF_MASK);
  localparam logic [31:0] A_OVF  = B + 32'(OFF_OVERFLOW);
  localparam logic [31:0] A_CNT  = B + 32'(OFF_COUNT);
  localparam logic [31:0] A_SW   = B + 32'(OFF_SWSET);

  logic       ph1 = 1'b0;
  logic       reset_b = 1'b0;
  logic [7:0] irq_in = 8'h00;
  logic [7:0] interrupts;

  irq_ctl_if bus();

  irq_ctl #(.BASE(B), .MASK_RESET(8'hFF)) dut (
    .ph1        (ph1),
    .reset_b    (reset_b),
    .irq_in     (irq_in),
    .bus        (bus),
    .interrupts (interrupts)
  );

  always #5 ph1 = ~ph1;

  int n_chk = 0;
  int n_pass = 0;

  // Reference state: registers plus the irq_in levels seen at the last three edges.
  logic [7:0]  m_pend, m_mask, m_ovf;
  int unsigned m_cnt;
  logic [7:0]  lvl1, lvl2, lvl3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  function automatic void model_reset();
    m_pend = 8'h00; m_mask = 8'hFF; m_ovf = 8'h00; m_cnt = 0;
    lvl1 = 8'h00; lvl2 = 8'h00; lvl3 = 8'h00;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] adr);
    if (adr[31:5] != B[31:5]) return 32'h0;
    case (adr[4:2])
      3'd0:    return {24'h0, m_pend};
      3'd1:    return {24'h0, m_mask};
      3'd2:    return {24'h0, m_ovf};
      3'd3:    return m_cnt;
      default: return 32'h0;
    endcase
  endfunction

  // An input that goes high before edge N becomes an event at edge N+2.
  function automatic void model_edge(input logic [7:0] irq, input logic [31:0] adr,
                                     input logic [31:0] wd, input logic we);
    logic st;
    int   r, acc_n;
    logic ev, clr, oc;
    st = we && (adr[31:5] == B[31:5]);
    r = int'(adr[4:2]);
    acc_n = 0;
    if (st && r == 3) m_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      ev  = (lvl2[i] && !lvl3[i]) || (st && r == 4 && wd[i]);
      clr = st && r == 0 && wd[i];
      oc  = st && r == 2 && wd[i];
      if (oc) m_ovf[i] = 1'b0;
      if (ev) begin
        if (m_pend[i] && !clr) m_ovf[i] = 1'b1;
        else begin m_pend[i] = 1'b1; acc_n++; end
      end else if (clr) m_pend[i] = 1'b0;
    end
    if (st && r == 1) m_mask = wd[7:0];
    m_cnt = (m_cnt + acc_n) % 65536;
    lvl3 = lvl2; lvl2 = lvl1; lvl1 = irq;
  endfunction

  task automatic step(input logic [7:0] irq, input logic [31:0] adr,
                      input logic [31:0] wd, input logic we);
    irq_in = irq;
    bus.dataadr = adr;
    bus.writedata = wd;
    bus.memwrite = we;
    #1;
    chk("read", bus.readdata, mread(adr));
    @(posedge ph1);
    model_edge(irq, adr, wd, we);
    #1;
    chk("irq_out", {24'h0, interrupts}, {24'h0, m_pend & m_mask});
    bus.memwrite = 1'b0;
  endtask

  task automatic idle(input logic [7:0] irq, input int n);
    for (int k = 0; k < n; k++) step(irq, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    bus.dataadr = adr;
    bus.memwrite = 1'b0;
    #1;
    chk(tag, bus.readdata, exp);
  endtask

  initial begin
    logic [7:0]  rirq;
    logic [31:0] radr;
    bus.dataadr = 32'h0; bus.writedata = 32'h0; bus.memwrite = 1'b0;
    model_reset();

    repeat (2) @(posedge ph1);
    #1;
    chk("rst_irq", {24'h0, interrupts}, 32'h0);
    rdchk("rst_mask", A_MASK, 32'hFF);
    rdchk("rst_pend", A_PEND, 32'h0);
    rdchk("rst_cnt",  A_CNT,  32'h0);
    reset_b = 1'b1;

    // irq_in[1] pulse: three-edge latency
    idle(8'h02, 2);
    chk("lat_2edges", {24'h0, interrupts}, 32'h0);
    idle(8'h02, 1);
    chk("lat_3edges", {24'h0, interrupts}, 32'h2);
    idle(8'h02, 2);
    idle(8'h00, 2);
    rdchk("pend_irq1", A_PEND, 32'h2);
    rdchk("cnt_irq1",  A_CNT,  32'h1);

    step(8'h00, A_PEND, 32'h02, 1'b1);
    chk("w1c_irq", {24'h0, interrupts}, 32'h0);
    rdchk("w1c_pend", A_PEND, 32'h0);

    // masked line still latches
    step(8'h00, A_MASK, 32'h00, 1'b1);
    idle(8'h01, 3);
    idle(8'h00, 2);
    rdchk("masked_pend", A_PEND, 32'h1);
    chk("masked_irq", {24'h0, interrupts}, 32'h0);
    step(8'h00, A_MASK, 32'h01, 1'b1);
    chk("unmask_irq", {24'h0, interrupts}, 32'h1);

    // double event on line 3 overflows
    step(8'h00, A_PEND, 32'hFF, 1'b1);
    step(8'h00, A_CNT,  32'h0,  1'b1);
    idle(8'h08, 2);
    idle(8'h00, 2);
    idle(8'h08, 2);
    idle(8'h00, 3);
    rdchk("ovf_pend", A_PEND, 32'h8);
    rdchk("ovf_ovf",  A_OVF,  32'h8);
    rdchk("ovf_cnt",  A_CNT,  32'h1);
    step(8'h00, A_OVF, 32'h08, 1'b1);
    rdchk("ovf_clr", A_OVF, 32'h0);

    // irq_in[2] rise lands on the same edge as a W1C of bit 2
    step(8'h00, A_SW, 32'h04, 1'b1);
    idle(8'h04, 2);
    step(8'h04, A_PEND, 32'h04, 1'b1);
    rdchk("race_pend", A_PEND, 32'h0C);
    rdchk("race_ovf",  A_OVF,  32'h0);
    rdchk("race_cnt",  A_CNT,  32'h3);
    idle(8'h00, 3);

    // random traffic; each irq level is held for two cycles
    rirq = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if (n % 2 == 0) rirq = 8'($urandom);
      if ($urandom_range(0, 7) == 0) radr = 32'hFFFF_FEE0 + 32'($urandom_range(0, 31));
      else radr = B + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      step(rirq, radr, $urandom, 1'($urandom_range(0, 1)));
    end

    // COUNT wrap: 8 events per SWSET/W1C pair
    idle(8'h00, 4);
    step(8'h00, A_PEND, 32'hFF, 1'b1);
    step(8'h00, A_OVF,  32'hFF, 1'b1);
    step(8'h00, A_CNT,  32'h0,  1'b1);
    step(8'h00, A_MASK, 32'hFF, 1'b1);
    for (int n = 0; n < 8191; n++) begin
      step(8'h00, A_SW,   32'hFF, 1'b1);
      step(8'h00, A_PEND, 32'hFF, 1'b1);
    end
    step(8'h00, A_SW,   32'h7F, 1'b1);
    step(8'h00, A_PEND, 32'hFF, 1'b1);
    rdchk("cnt_ffff", A_CNT, 32'hFFFF);
    step(8'h00, A_SW, 32'hFF, 1'b1);
    chk("all_irq", {24'h0, interrupts}, 32'hFF);
    rdchk("cnt_wrap", A_CNT, 32'h7);

    // asynchronous reset between edges
    reset_b = 1'b0;
    #1;
    chk("arst_irq", {24'h0, interrupts}, 32'h0);
    model_reset();
    rdchk("arst_mask", A_MASK, 32'hFF);
    rdchk("arst_pend", A_PEND, 32'h0);
    rdchk("arst_cnt",  A_CNT,  32'h0);
    rdchk("arst_ovf",  A_OVF,  32'h0);
    @(posedge ph1);
    #1;
    reset_b = 1'b1;

    rirq = 8'h00;
    for (int n = 0; n < 200; n++) begin
      if (n % 2 == 0) rirq = 8'($urandom);
      radr = B + 32'($urandom_range(0, 7) * 4);
      step(rirq, radr, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
